// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The serial line is synchronised, the start bit is checked at its midpoint,
// then 8 data bits (LSB first) and the stop bit are sampled at CLK_PER_BIT spacing.
// Each good byte is presented with a one-cycle data_valid strobe.
// A bad stop bit raises a one-cycle frame_err strobe, and the byte is discarded.
module uart_rx #(
    parameter int CLK_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'((CLK_PER_BIT - 1) / 2);

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic        armed;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_idx;
    logic [7:0]  shift;

    // Two-flop synchroniser. It resets to the idle-high line level, so leaving reset does not look like a start edge.
    // NOTE: asynchronous active-low reset goes in the sensitivity list; every state flop gets a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM. The strobes default low every cycle, so each one lasts exactly one clock.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b1;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end
                    // A line still low after a framing error stays disarmed until it has gone high again.
                    if (armed && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        // A start bit that has gone high again by its midpoint is a glitch: drop it without a strobe.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt              <= '0;
                        shift[bit_idx[2:0]] <= rx_s;
                        bit_idx              <= bit_idx + 4'd1;
                        if (bit_idx == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // state is itself a flop, so busy is free of glitches.
    assign busy = (state != IDLE);

endmodule
